input_conditioner: RTL
======================

Name: input_conditioner

Overview:
Multi-channel input conditioner: successor to the 2-flop single-bit synchroniser. Each of WIDTH asynchronous inputs passes through a parametrised synchroniser chain, then a per-channel debounce filter. Each channel produces a stable level plus single-cycle rise and fall pulses. Sits between the top-level input pins and the CPU control/IO logic; replaces ad-hoc per-pin synchronisers.

Parameters:
WIDTH, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEBOUNCE_CYCLES, 4, consecutive qualifying ticks a new value must persist before level_o accepts it (>=1)
RESET_VALUE, {WIDTH{1'b0}}, reset value of every sync flop and of level_o per channel

Ports:
clk_i  input  1  system clock, all state on rising edge
reset_ni  input  1  asynchronous, active-low reset
tick_i  input  1  debounce sample enable; tie high to count every clock
inputs_i  input  WIDTH  raw asynchronous inputs
level_o  output  WIDTH  debounced, synchronised level per channel (registered)
rise_o  output  WIDTH  one-cycle pulse per channel on level_o 0->1 (registered)
fall_o  output  WIDTH  one-cycle pulse per channel on level_o 1->0 (registered)
changed_o  output  1  OR-reduction of rise_o|fall_o (combinational from registers)

Behaviour:
- One clock, async active-low reset. Reset asserts immediately, independent of clk_i. While reset_ni=0: sync chains = RESET_VALUE, level_o = RESET_VALUE, counters = 0, rise_o = fall_o = 0, changed_o = 0.
- Sync chain per channel: stage0 <= inputs_i[n]; stage k <= stage k-1. synced[n] = last stage. No logic between stages.
- Debounce counter per channel, width $clog2(DEBOUNCE_CYCLES+1). Per clock:
  - synced == level: counter <= 0, regardless of tick_i.
  - synced != level, tick_i=0: counter holds.
  - synced != level, tick_i=1, counter < DEBOUNCE_CYCLES-1: counter increments.
  - synced != level, tick_i=1, counter == DEBOUNCE_CYCLES-1: level flips, counter <= 0.
- Any bounce back to the old value before acceptance clears the counter. Filtering restarts from zero.
- rise_o[n]/fall_o[n] are registered in the same edge that updates level_o[n]. They are high for exactly the first cycle level_o shows the new value.
- Latency, tick_i=1, clean step on inputs_i before edge 1: synced changes at edge SYNC_STAGES; level_o and the pulse change at edge SYNC_STAGES+DEBOUNCE_CYCLES. Defaults: edge 6.
- DEBOUNCE_CYCLES=1: pure synchroniser plus one register, latency SYNC_STAGES+1.
- Channels are fully independent. Simultaneous changes on several channels yield simultaneous pulses.
- Reset mid-count: the counter is discarded and no pulse is produced. After release, channels whose input differs from RESET_VALUE run a full latency before transitioning.
- Pulses never occur on reset release itself.

Optional Feature:
INPUT_CONDITIONER_STICKY_EN
- Defined: adds ports clear_i (input, WIDTH) and rise_sticky_o / fall_sticky_o (output, WIDTH).
  - Sticky bit sets on its pulse and holds until clear_i[n]=1 on a clock edge.
  - Set and clear in the same cycle: set wins.
  - Reset value 0.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Reset: reset_ni=0 with inputs_i=4'hF, then release -> level_o=0, rise_o=0 for SYNC_STAGES+DEBOUNCE_CYCLES-1 cycles; rise_o=4'hF for exactly 1 cycle at edge 6; level_o=4'hF thereafter.
- Clean step, defaults, tick_i=1: inputs_i[0] 0->1 before edge 1 -> level_o[0]=1 and rise_o[0]=1 after edge 6; rise_o[0]=0 after edge 7; other channels unchanged.
- Bounce: inputs_i[1] high for 3 cycles, low 1, then high steady -> no premature change; level_o[1] rises exactly 4 ticks after the final steady synced value; one rise pulse only.
- tick_i gating: tick_i high every 3rd cycle, step on ch2 -> level_o[2] changes only on the 4th qualifying tick; counter holds between ticks.
- Async reset mid-count: assert reset_ni at counter=2 between edges -> outputs zero immediately, no fall/rise pulse, full latency after release.
- Sticky (macro defined): fall on ch3 -> fall_sticky_o[3]=1 held; clear_i[3] coinciding with a new fall pulse -> stays 1; clear alone -> 0 next edge.

Source files
------------

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Multi-channel input conditioner. Each of WIDTH asynchronous inputs passes
// through a SYNC_STAGES-deep synchroniser chain followed by a per-channel
// debounce filter. A new synchronised value must persist for DEBOUNCE_CYCLES
// qualifying ticks before the channel's level accepts it. Each channel
// reports its stable level plus single-cycle rise and fall pulses.
//
// Ports:
//   clk_i          system clock, all state updates on the rising edge
//   reset_ni       asynchronous, active-low reset
//   tick_i         debounce sample enable (tie high to count every clock)
//   inputs_i       raw asynchronous inputs, one bit per channel
//   level_o        debounced, synchronised level per channel (registered)
//   rise_o         one-cycle pulse when level_o goes 0->1 (registered)
//   fall_o         one-cycle pulse when level_o goes 1->0 (registered)
//   changed_o      OR of all rise_o/fall_o bits
//
// Optional feature, enabled by defining INPUT_CONDITIONER_STICKY_EN:
//   clear_i        per-channel clear for the sticky flags
//   rise_sticky_o  set by a rise pulse, held until cleared
//   fall_sticky_o  set by a fall pulse, held until cleared
// -----------------------------------------------------------------------------
module input_conditioner #(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      SYNC_STAGES     = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             tick_i,
    input  logic [WIDTH-1:0] inputs_i,
`ifdef INPUT_CONDITIONER_STICKY_EN
    input  logic [WIDTH-1:0] clear_i,
    output logic [WIDTH-1:0] rise_sticky_o,
    output logic [WIDTH-1:0] fall_sticky_o,
`endif
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             changed_o
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    // Count value on which the next qualifying tick accepts the new level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // -------------------------------------------------------------------------
    // Synchroniser chains: stage 0 samples the pins, the last stage is the
    // first one considered safe to use. No logic between stages.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] synced;

    // NOTE: every stage is a real flop with a reset, so the array is reset
    // element by element; this is not a RAM and must not be treated as one.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= RESET_VALUE;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage sample the old
            // value of its predecessor, which is what builds a shift chain.
            sync_q[0] <= inputs_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Debounce filter: the counter tracks how many qualifying ticks the
    // synchronised value has differed from the accepted level. Any return to
    // the accepted level restarts the filtering from zero.
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int n = 0; n < WIDTH; n++) begin
            cnt_d[n] = cnt_q[n];
            if (synced[n] == level_q[n]) begin
                cnt_d[n] = '0;
            end else if (tick_i) begin
                if (cnt_q[n] == CNT_LAST) begin
                    level_d[n] = ~level_q[n];
                    rise_d[n]  = ~level_q[n];
                    fall_d[n]  = level_q[n];
                    cnt_d[n]   = '0;
                end else begin
                    cnt_d[n] = cnt_q[n] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            level_q <= RESET_VALUE;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int n = 0; n < WIDTH; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int n = 0; n < WIDTH; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    assign level_o   = level_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign changed_o = |(rise_q | fall_q);

`ifdef INPUT_CONDITIONER_STICKY_EN
    // -------------------------------------------------------------------------
    // Sticky flags: set on the same edge as the pulse they capture, so a set
    // arriving together with a clear wins.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] rise_sticky_q, rise_sticky_d;
    logic [WIDTH-1:0] fall_sticky_q, fall_sticky_d;

    assign rise_sticky_d = (rise_sticky_q & ~clear_i) | rise_d;
    assign fall_sticky_d = (fall_sticky_q & ~clear_i) | fall_d;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rise_sticky_q <= '0;
            fall_sticky_q <= '0;
        end else begin
            rise_sticky_q <= rise_sticky_d;
            fall_sticky_q <= fall_sticky_d;
        end
    end

    assign rise_sticky_o = rise_sticky_q;
    assign fall_sticky_o = fall_sticky_q;
`endif

endmodule
